// File: rtl/puf_response_gen.sv
// RO-pair PUF response generator: per challenge index, settle, count edges
// of both oscillators over a window, and emit one comparison bit serially.
module puf_response_gen #(
  parameter int NBITS      = 256,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ro_a,
  input  logic                     ro_b,
  output logic [$clog2(NBITS)-1:0] sel,
  output logic                     s_out,
  output logic                     en_out,
  output logic                     busy,
  output logic                     done
);

  localparam int TMAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = $clog2(NBITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [TW-1:0]    r_tmr;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [1:0]       r_sync_a;
  logic [1:0]       r_sync_b;
  logic             r_prev_a;
  logic             r_prev_b;
  logic             r_edge_a;
  logic             r_edge_b;
  logic             w_settle_end;
  logic             w_meas_end;
  logic             w_last;

  assign w_settle_end = (r_tmr == TW'(SETTLE_CYC - 1));
  assign w_meas_end   = (r_tmr == TW'(WINDOW - 1));
  assign w_last       = (sel == SW'(NBITS - 1));

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start && !done) w_nxt = S_SETTLE;
      S_SETTLE:  if (w_settle_end) w_nxt = S_MEASURE;
      S_MEASURE: if (w_meas_end) w_nxt = S_EMIT;
      S_EMIT:    w_nxt = w_last ? S_DONE : S_SETTLE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
      r_edge_a <= 1'b0;
      r_edge_b <= 1'b0;
      sel      <= '0;
      s_out    <= 1'b0;
      en_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[0], ro_a};
      r_sync_b <= {r_sync_b[0], ro_b};
      r_prev_a <= r_sync_a[1];
      r_prev_b <= r_sync_b[1];
      r_edge_a <= r_sync_a[1] & ~r_prev_a;
      r_edge_b <= r_sync_b[1] & ~r_prev_b;

      r_state <= w_nxt;
      if (w_nxt != r_state || r_state == S_IDLE)
        r_tmr <= '0;
      else
        r_tmr <= r_tmr + 1'b1;

      if (r_state == S_IDLE && w_nxt == S_SETTLE)
        sel <= '0;
      else if (r_state == S_EMIT && w_nxt == S_SETTLE)
        sel <= sel + 1'b1;

      // Counters only run inside the window and stick at all-ones
      if (r_state != S_MEASURE) begin
        r_cnt_a <= '0;
        r_cnt_b <= '0;
      end else begin
        if (r_edge_a && r_cnt_a != '1)
          r_cnt_a <= r_cnt_a + 1'b1;
        if (r_edge_b && r_cnt_b != '1)
          r_cnt_b <= r_cnt_b + 1'b1;
      end

      en_out <= (r_state == S_EMIT);
      s_out  <= (r_state == S_EMIT) && (r_cnt_a > r_cnt_b);
      busy   <= (r_state == S_SETTLE) || (r_state == S_MEASURE) ||
                (r_state == S_EMIT);
      done   <= (r_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_puf_response_gen.sv
// Directed bench for puf_response_gen: main instance (4 bits, window 16)
// and a narrow-counter instance exercising saturation.
module tb_puf_response_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       ro_a, ro_b;
  logic       ro_a2, ro_b2;
  logic [1:0] sel;
  logic       s_out, en_out, busy, done;
  logic [0:0] sel2;
  logic       s_out2, en_out2, busy2, done2;
  logic [7:0] ph = 8'd0;
  int         mode = 0;
  int         vectors = 0;
  int         errs = 0;

  always #5 clk = ~clk;
  always @(negedge clk) ph <= ph + 8'd1;

  // mode 0: a=clk/4 b=clk/8, 1: identical, 2: fast side alternates by sel
  always_comb begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    case (mode)
      0: begin ro_a = ph[1]; ro_b = ph[2]; end
      1: begin ro_a = ph[1]; ro_b = ph[1]; end
      2: begin
        ro_a = sel[0] ? 1'b0 : ph[1];
        ro_b = sel[0] ? ph[1] : 1'b0;
      end
      default: ;
    endcase
  end

  assign ro_a2 = ph[1];
  assign ro_b2 = 1'b0;

  puf_response_gen #(
    .NBITS(4), .WINDOW(16), .SETTLE_CYC(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ro_a(ro_a), .ro_b(ro_b), .sel(sel),
    .s_out(s_out), .en_out(en_out), .busy(busy), .done(done)
  );

  puf_response_gen #(
    .NBITS(2), .WINDOW(64), .SETTLE_CYC(2), .CNT_W(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .ro_a(ro_a2), .ro_b(ro_b2), .sel(sel2),
    .s_out(s_out2), .en_out(en_out2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one run on instance d; check every cycle until after done.
  task automatic run(input int d, input int per, input int nb,
                     input logic [3:0] expb, input bit repulse);
    logic en, so, dn, bz;
    int   last;
    last = nb * per + 1;
    @(negedge clk);
    if (d == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start2 = 1'b0;
    for (int n = 1; n <= last + 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      en = (d == 0) ? en_out : en_out2;
      so = (d == 0) ? s_out : s_out2;
      dn = (d == 0) ? done : done2;
      bz = (d == 0) ? busy : busy2;
      if (n % per == 0 && n / per <= nb) begin
        chk($sformatf("en d%0d n=%0d", d, n), 32'(en), 32'd1);
        chk($sformatf("bit d%0d i=%0d", d, n / per - 1), 32'(so),
            32'(expb[n / per - 1]));
      end else begin
        chk($sformatf("en d%0d n=%0d", d, n), 32'(en), 32'd0);
        chk($sformatf("s_out idle d%0d n=%0d", d, n), 32'(so), 32'd0);
      end
      chk($sformatf("done d%0d n=%0d", d, n), 32'(dn),
          32'(n == last));
      if (n == 1 || n == last - 1 || n == last)
        chk($sformatf("busy d%0d n=%0d", d, n), 32'(bz),
            32'(n != last));
      if (repulse && n == 30 && d == 0) start = 1'b1;
      if (n == 31) start = 1'b0;
    end
    chk($sformatf("sel hold d%0d", d),
        (d == 0) ? 32'(sel) : 32'(sel2), 32'(nb - 1));
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sel", 32'(sel), 32'd0);
    chk("rst en", 32'(en_out), 32'd0);
    chk("rst s_out", 32'(s_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    mode = 0;
    run(0, 19, 4, 4'b1111, 1'b0);
    mode = 1;
    run(0, 19, 4, 4'b0000, 1'b0);
    mode = 2;
    run(0, 19, 4, 4'b0101, 1'b0);
    mode = 0;
    run(0, 19, 4, 4'b1111, 1'b1);

    // Reset inside the bit-2 measurement window
    mode = 2;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (en_out) pulses++;
    end
    chk("pulses before rst", 32'(pulses), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid rst sel", 32'(sel), 32'd0);
    chk("mid rst en", 32'(en_out), 32'd0);
    chk("mid rst s_out", 32'(s_out), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (en_out || busy || done) pulses++;
    end
    chk("quiet after rst", 32'(pulses), 32'd0);
    run(0, 19, 4, 4'b0101, 1'b0);

    run(1, 67, 2, 4'b0011, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
